// File: rtl/stream_demux_1xn_pkg.sv
// rtl/stream_demux_1xn_pkg.sv - shared limits and helpers for the 1-to-N stream demux
//
// Purpose: channel-count limit, default drop-counter width and a constant
//          clog2 used to derive select widths.
// Ports:   none (package).
package stream_demux_1xn_pkg;

  localparam int MAX_N_OUT     = 32;
  localparam int CNT_W_DEFAULT = 8;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_demux_1xn_if.sv
// rtl/stream_demux_1xn_if.sv - producer and per-channel consumer handshakes of the demux
//
// Purpose: groups the input stream (in_*) and the N-channel output stream (out_*).
// Signals: in_valid/in_ready/in_data/in_sel/in_bcast  - single producer side
//          out_valid/out_ready (one bit per channel), out_data (shared bus)
// Modports: slave  - the demux itself
//           master - the environment driving the producer and consumers
interface stream_demux_1xn_if
  import stream_demux_1xn_pkg::*;
#(
  parameter int N_OUT = 8,
  parameter int DW    = 8
);
  localparam int SEL_W = clog2(N_OUT);

  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic [SEL_W-1:0] in_sel;
  logic             in_bcast;
  logic [N_OUT-1:0] out_valid;
  logic [N_OUT-1:0] out_ready;
  logic [DW-1:0]    out_data;

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/stream_demux_1xn_dec.sv
// rtl/stream_demux_1xn_dec.sv - select-to-onehot decoder with out-of-range flag
//
// Purpose: combinational generalisation of the 1x2 demux cell.
// Ports: sel_i    - channel select
//        en_i     - enable; onehot_o is all zero when low
//        onehot_o - N_OUT-bit one-hot of sel_i
//        oor_o    - sel_i does not name a channel (only possible for non power-of-2 N_OUT)
module stream_demux_1xn_dec
  import stream_demux_1xn_pkg::*;
#(
  parameter int N_OUT = 8,
  parameter int SEL_W = clog2(N_OUT)
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [N_OUT-1:0] onehot_o,
  output logic             oor_o
);

  always_comb begin
    onehot_o = '0;
    oor_o    = (int'(sel_i) >= N_OUT);
    for (int k = 0; k < N_OUT; k++) begin
      onehot_o[k] = en_i && (int'(sel_i) == k);
    end
  end

endmodule

// File: rtl/stream_demux_1xn.sv
// rtl/stream_demux_1xn.sv - registered 1-to-N stream demultiplexer with broadcast
//
// Purpose: holds one item and a pending-delivery mask; each channel completes
//          independently, and a new item is taken once every pending channel
//          is done (or finishing in the same cycle).
// Ports: clk, rst  - clock, asynchronous active-high reset
//        bus       - slave side of stream_demux_1xn_if (input stream + N outputs)
//        err_drop  - one-cycle pulse after an item with a bad select was dropped
//        drop_cnt  - saturating count of dropped items
module stream_demux_1xn
  import stream_demux_1xn_pkg::*;
#(
  parameter int N_OUT = 8,
  parameter int DW    = 8,
  parameter int SEL_W = clog2(N_OUT),
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  stream_demux_1xn_if.slave  bus,
  output logic               err_drop,
  output logic [CNT_W-1:0]   drop_cnt
);

  logic [N_OUT-1:0] pend_q, pend_d;
  logic [DW-1:0]    data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_OUT-1:0] sel_onehot;
  logic             sel_oor;
  logic             accept;
  logic             drop;

  // Decoder disabled for broadcast so its one-hot never leaks into the mask.
  stream_demux_1xn_dec #(
    .N_OUT (N_OUT),
    .SEL_W (SEL_W)
  ) u_dec (
    .sel_i    (bus.in_sel),
    .en_i     (~bus.in_bcast),
    .onehot_o (sel_onehot),
    .oor_o    (sel_oor)
  );

  // Ready when no pending channel is being held off this cycle; this is what
  // lets the register refill every cycle under full consumer readiness.
  assign bus.in_ready  = ((pend_q & ~bus.out_ready) == '0);
  assign accept        = bus.in_valid & bus.in_ready;
  assign drop          = accept & ~bus.in_bcast & sel_oor;

  assign bus.out_valid = pend_q;
  assign bus.out_data  = data_q;
  assign err_drop      = err_q;
  assign drop_cnt      = cnt_q;

  always_comb begin
    pend_d = pend_q & ~bus.out_ready;
    data_d = data_q;
    err_d  = 1'b0;
    cnt_d  = cnt_q;
    if (accept) begin
      if (bus.in_bcast) begin
        pend_d = '1;
        data_d = bus.in_data;
      end else if (!sel_oor) begin
        pend_d = sel_onehot;
        data_d = bus.in_data;
      end else begin
        pend_d = '0;
      end
    end
    if (drop) begin
      err_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// tb/tb_stream_demux_1xn.sv - scoreboard bench for stream_demux_1xn (N_OUT=8 and N_OUT=6)
module tb_stream_demux_1xn;
  import stream_demux_1xn_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_demux_1xn_if #(.N_OUT(8), .DW(8)) if8 ();
  stream_demux_1xn_if #(.N_OUT(6), .DW(8)) if6 ();

  logic       err8, err6;
  logic [7:0] cnt8, cnt6;

  stream_demux_1xn #(.N_OUT(8), .DW(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .bus(if8), .err_drop(err8), .drop_cnt(cnt8)
  );
  stream_demux_1xn #(.N_OUT(6), .DW(8), .CNT_W(8)) dut6 (
    .clk(clk), .rst(rst), .bus(if6), .err_drop(err6), .drop_cnt(cnt6)
  );

  // Uniform 8-channel view of both instances (index 0: N=8, index 1: N=6).
  logic [7:0] ov[2], orr[2], od[2], id[2], dc[2];
  logic       iv[2], ir[2], ib[2], ed[2];
  logic [2:0] is[2];
  int         nch[2];

  assign ov[0] = if8.out_valid;           assign ov[1] = {2'b00, if6.out_valid};
  assign orr[0] = if8.out_ready;          assign orr[1] = {2'b00, if6.out_ready};
  assign od[0] = if8.out_data;            assign od[1] = if6.out_data;
  assign id[0] = if8.in_data;             assign id[1] = if6.in_data;
  assign dc[0] = cnt8;                    assign dc[1] = cnt6;
  assign iv[0] = if8.in_valid;            assign iv[1] = if6.in_valid;
  assign ir[0] = if8.in_ready;            assign ir[1] = if6.in_ready;
  assign ib[0] = if8.in_bcast;            assign ib[1] = if6.in_bcast;
  assign ed[0] = err8;                    assign ed[1] = err6;
  assign is[0] = if8.in_sel;              assign is[1] = if6.in_sel;

  // Reference model: per-channel queue of items still owed to that consumer,
  // expected drop pulse and saturating drop tally.
  logic [7:0] expq[2][8][$];
  logic       exp_err[2];
  int         exp_cnt[2];
  int         n_vec = 0;
  int         n_mis = 0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s (N_OUT=%0d) at %0t: got 0x%0h, expected 0x%0h", nm, nch[d], $time, act, exp);
    end
  endtask

  // Input monitor: records what each accepted item owes to which channels.
  initial begin : mon_in
    logic dropped;
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst) begin
          dropped = 1'b0;
          if (iv[d] && ir[d]) begin
            if (ib[d]) begin
              for (int k = 0; k < nch[d]; k++) expq[d][k].push_back(id[d]);
            end else if (int'(is[d]) < nch[d]) begin
              expq[d][is[d]].push_back(id[d]);
            end else begin
              dropped = 1'b1;
            end
          end
          exp_err[d] = dropped;
          if (dropped && exp_cnt[d] < 255) exp_cnt[d] = exp_cnt[d] + 1;
        end
      end
    end
  end

  // Output monitor: compares channel state and pops each completed delivery.
  initial begin : mon_out
    logic [7:0] owed;
    logic       can_take;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          for (int k = 0; k < 8; k++) expq[d][k].delete();
          exp_err[d] = 1'b0;
          exp_cnt[d] = 0;
        end else begin
          owed     = '0;
          can_take = 1'b1;
          for (int k = 0; k < nch[d]; k++) begin
            owed[k] = (expq[d][k].size() != 0);
            if (owed[k] && !orr[d][k]) can_take = 1'b0;
          end
          chk("out_valid", d, ov[d], owed);
          chk("in_ready", d, ir[d], can_take);
          chk("err_drop", d, ed[d], exp_err[d]);
          chk("drop_cnt", d, dc[d], exp_cnt[d]);
          for (int k = 0; k < nch[d]; k++) begin
            if (ov[d][k] && orr[d][k] && expq[d][k].size() != 0)
              chk("out_data", d, od[d], expq[d][k].pop_front());
          end
        end
      end
    end
  end

  task automatic drive(input int d, input logic v, input logic b, input logic [2:0] s,
                       input logic [7:0] dat, input logic [7:0] rdy);
    if (d == 0) begin
      if8.in_valid = v; if8.in_bcast = b; if8.in_sel = s; if8.in_data = dat; if8.out_ready = rdy;
    end else begin
      if6.in_valid = v; if6.in_bcast = b; if6.in_sel = s; if6.in_data = dat; if6.out_ready = rdy[5:0];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all(input int cycles);
    drive(0, 1'b0, 1'b0, 3'd0, 8'h00, 8'hFF);
    drive(1, 1'b0, 1'b0, 3'd0, 8'h00, 8'hFF);
    repeat (cycles) step();
  endtask

  initial begin
    nch[0] = 8;
    nch[1] = 6;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 3'd0, 8'h00, 8'hFF);
    drive(1, 1'b0, 1'b0, 3'd0, 8'h00, 8'hFF);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_all(2);

    // Single unicast to channel 5.
    drive(0, 1'b1, 1'b0, 3'd5, 8'hA5, 8'hFF); step();
    idle_all(2);

    // Backpressure on channel 2 for three cycles; next item offered throughout.
    drive(0, 1'b1, 1'b0, 3'd2, 8'h11, 8'hFB); step();
    repeat (3) begin drive(0, 1'b1, 1'b0, 3'd6, 8'h22, 8'hFB); step(); end
    drive(0, 1'b1, 1'b0, 3'd6, 8'h22, 8'hFF); step();
    idle_all(2);

    // Broadcast with split completion; a follow-up item waits for the last channel.
    drive(0, 1'b1, 1'b1, 3'd0, 8'h3C, 8'h00); step();
    drive(0, 1'b1, 1'b0, 3'd1, 8'h44, 8'h0F); step();
    repeat (2) begin drive(0, 1'b1, 1'b0, 3'd1, 8'h44, 8'h00); step(); end
    drive(0, 1'b1, 1'b0, 3'd1, 8'h44, 8'hF0); step();
    idle_all(2);

    // Back-to-back streaming.
    for (int i = 0; i < 16; i++) begin
      drive(0, 1'b1, 1'b0, 3'(i % 8), 8'(8'h80 + i), 8'hFF);
      step();
    end
    idle_all(2);

    // Bad select on the 6-channel instance, then drive the counter into saturation.
    drive(1, 1'b1, 1'b0, 3'd7, 8'h99, 8'hFF); step();
    idle_all(2);
    chk("drop_cnt_first", 1, cnt6, 1);
    for (int i = 0; i < 300; i++) begin
      drive(1, 1'b1, 1'b0, 3'(6 + (i % 2)), 8'($urandom), 8'hFF);
      step();
    end
    idle_all(2);
    chk("drop_cnt_sat", 1, cnt6, 255);

    // Randomised traffic on both instances.
    for (int i = 0; i < 1500; i++) begin
      for (int d = 0; d < 2; d++) begin
        drive(d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
              3'($urandom_range(0, 7)), 8'($urandom),
              8'($urandom) | 8'($urandom));
      end
      step();
    end
    idle_all(3);

    // Asynchronous reset while a broadcast still owes channels 0-3.
    drive(0, 1'b1, 1'b1, 3'd0, 8'h5A, 8'h00); step();
    drive(0, 1'b0, 1'b0, 3'd0, 8'h00, 8'hF0); step();
    chk("pend_before_rst", 0, if8.out_valid, 8'h0F);
    drive(0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    #1 rst = 1'b1;
    #1 chk("rst_async_out_valid", 0, if8.out_valid, 8'h00);
    chk("rst_async_out_data", 0, if8.out_data, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 1'b1, 1'b0, 3'd3, 8'h77, 8'hFF); step();
    idle_all(3);

    for (int d = 0; d < 2; d++)
      for (int k = 0; k < nch[d]; k++)
        chk("undelivered", d, expq[d][k].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
